// File: rtl/kamus_pkg.sv
// kamus_pkg -- shared types for the kamus fetch stage.
//   fetch_state_e : fetch FSM states
//   fetch_entry_t : one instruction buffer entry {pc, instr}
//   word_align()  : clears the byte-offset bits of an address
package kamus_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/kamus_fifo.sv
// kamus_fifo -- generic synchronous FIFO with flush.
//   clk_i/rst_ni : clock, async active-low reset
//   flush_i      : empties the FIFO (wins over push/pop)
//   push_i/wdata_i, pop_i/rdata_o : write / read ports, rdata_o is the head
//   full_o, empty_o, count_o : occupancy status
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module kamus_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign full_o  = (cnt == CW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign count_o = cnt;
  assign rdata_o = mem[rptr];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage needs no reset: entries are only visible through a valid count
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wptr] <= wdata_i;
  end

endmodule

// File: rtl/kamus_if.sv
// kamus_if -- instruction fetch stage.
//   clk_i/rst_ni   : clock, async active-low reset
//   imem_*         : req/gnt request channel, in-order rvalid/rdata responses
//   redirect_i/_pc : control-flow change, flushes and retargets fetch
//   instr_*/pc_o   : valid/ready instruction stream toward decode
// Requests are throttled so outstanding + buffered never exceeds FIFO_DEPTH,
// hence every response always has a free buffer slot.
module kamus_if
  import kamus_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]    outst_q, outst_d, drop_q, drop_d, fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic             gnt_xfer, rsp_acc, push, pop;
  fetch_entry_t     wentry, head;
  logic [ENTRY_W-1:0] fifo_rdata;

  // a response with nothing owed is ignored
  assign rsp_acc  = imem_rvalid_i & (outst_q != '0);
  assign gnt_xfer = imem_req_o & imem_gnt_i;
  // redirect wins over pop; responses during a redirect or DRAIN are stale
  assign pop      = instr_valid_o & instr_ready_i & ~redirect_i;
  assign push     = rsp_acc & (state_q == FETCH) & ~redirect_i;
  assign outst_d  = outst_q + CW'(gnt_xfer) - CW'(rsp_acc);

  assign imem_req_o  = (state_q == FETCH) & ~redirect_i &
                       (({1'b0, outst_q} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc_q;

  assign wentry = '{pc: resp_pc_q, instr: imem_rdata_i};
  assign head   = fifo_rdata;

  assign instr_valid_o = ~fifo_empty;
  assign instr_o       = instr_valid_o ? head.instr : '0;
  assign pc_o          = instr_valid_o ? head.pc    : '0;

  kamus_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= word_align(BOOT_ADDR);
      resp_pc_q  <= word_align(BOOT_ADDR);
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    if (gnt_xfer) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push)     resp_pc_d  = resp_pc_q + 32'd4;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: state_d = FETCH;
      DRAIN: begin
        if (rsp_acc) begin
          drop_d = drop_q - CW'(1);
          if (drop_q == CW'(1)) state_d = FETCH;
        end else if (drop_q == '0) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
      resp_pc_d  = word_align(redirect_pc_i);
      // a redirect inside DRAIN only retargets; the drop count keeps running
      if (state_q != DRAIN) begin
        if (outst_d != '0) begin
          state_d = DRAIN;
          drop_d  = outst_d;
        end else begin
          state_d = FETCH;
        end
      end
    end
  end

  a_no_orphan_rvalid: assert property (
    @(posedge clk_i) disable iff (!rst_ni) imem_rvalid_i |-> (outst_q != '0));

endmodule

// File: tb/tb_kamus_if.sv
// tb_kamus_if -- randomized bench for kamus_if with a transaction-level
// memory and instruction-stream model (pending response queue + expected
// buffer contents), plus directed scenarios.
module tb_kamus_if;
  import kamus_pkg::*;

  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect = 1'b0, instr_ready = 1'b0, instr_valid;
  logic [31:0] redirect_pc = '0, instr_o, pc_o;

  always #5 clk = ~clk;

  kamus_if #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
  pend_t        pend[$];       // responses the memory still owes
  fetch_entry_t sb_q[$];       // instructions the DUT should be buffering
  logic [31:0]  exp_fetch;
  bit           idle_next;
  int           cyc = 0;

  int gnt_pct = 100, rv_pct = 100, rv_max = 0, rdy_pct = 100;
  bit rv_hold = 0, nop_mode = 1;
  logic [31:0] grant_log[$], pop_log[$];
  int first_rv_cyc = -1, first_vld_cyc = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return nop_mode ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
  endfunction

  function automatic bit has_stale();
    foreach (pend[i]) if (pend[i].stale) return 1;
    return 0;
  endfunction

  // called at a negedge; leaves rst_n released at a negedge (IDLE cycle next)
  task automatic do_reset();
    imem_gnt = 0; imem_rvalid = 0; redirect = 0;
    rst_n = 0;
    #1;
    chk("rst_req",   imem_req,    32'd0);
    chk("rst_addr",  imem_addr,   BOOT);
    chk("rst_vld",   instr_valid, 32'd0);
    chk("rst_instr", instr_o,     32'd0);
    chk("rst_pc",    pc_o,        32'd0);
    pend.delete(); sb_q.delete();
    exp_fetch = BOOT; idle_next = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // one clock cycle, entered and left at a negedge
  task automatic cycle(input bit do_redir, input logic [31:0] rpc);
    bit    rv, g, pop, exp_req;
    int    occ;
    pend_t pe;
    rv = (pend.size() > 0) && !rv_hold && (pend[0].due <= cyc) &&
         ($urandom_range(99) < rv_pct);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend[0].addr) : $urandom();
    redirect    = do_redir;
    redirect_pc = do_redir ? rpc : $urandom();
    instr_ready = ($urandom_range(99) < rdy_pct);
    #1;
    occ     = pend.size() + sb_q.size();
    exp_req = !idle_next && !do_redir && !has_stale() && (occ < DEPTH);
    chk("req",  imem_req,    exp_req);
    chk("addr", imem_addr,   exp_fetch);
    chk("vld",  instr_valid, sb_q.size() != 0);
    if (sb_q.size() == 0) begin
      chk("instr_idle", instr_o, 32'd0);
      chk("pc_idle",    pc_o,    32'd0);
    end else begin
      chk("pc",    pc_o,    sb_q[0].pc);
      chk("instr", instr_o, sb_q[0].instr);
    end
    if (instr_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (rv && first_rv_cyc < 0) first_rv_cyc = cyc;
    g = imem_req && ($urandom_range(99) < gnt_pct);
    imem_gnt = g;
    #1;
    pop = (sb_q.size() != 0) && instr_ready && !do_redir;
    if (pop) begin
      pop_log.push_back(sb_q[0].pc);
      void'(sb_q.pop_front());
    end
    if (rv) begin
      pe = pend.pop_front();
      if (!do_redir && !pe.stale)
        sb_q.push_back('{pc: pe.addr, instr: mem_word(pe.addr)});
    end
    if (g) begin
      grant_log.push_back(exp_fetch);
      pend.push_back('{addr: exp_fetch, due: cyc + 1 + $urandom_range(rv_max), stale: 1'b0});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (do_redir) begin
      foreach (pend[i]) pend[i].stale = 1;
      sb_q.delete();
      exp_fetch = {rpc[31:2], 2'b00};
    end
    idle_next = 0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);

    // basic streaming
    nop_mode = 1; gnt_pct = 100; rv_pct = 100; rv_max = 0; rdy_pct = 100; rv_hold = 0;
    do_reset();
    grant_log.delete(); pop_log.delete(); first_rv_cyc = -1; first_vld_cyc = -1;
    run(10);
    chk("s1_ngnt", grant_log.size() >= 3, 32'd1);
    chk("s1_a0", grant_log[0], 32'h0);
    chk("s1_a1", grant_log[1], 32'h4);
    chk("s1_a2", grant_log[2], 32'h8);
    chk("s1_vld_lat", first_vld_cyc, first_rv_cyc + 1);
    chk("s1_first_pc", pop_log[0], 32'h0);

    // decoder stalled: fill the buffer, then stop requesting
    rdy_pct = 0;
    do_reset();
    grant_log.delete();
    run(12);
    chk("s2_ngnt", grant_log.size(), 32'd2);
    chk("s2_req", imem_req, 32'd0);
    chk("s2_instr", instr_o, 32'h0000_0013);
    chk("s2_pc", pc_o, 32'h0);

    // redirect with two owed responses
    rdy_pct = 100; rv_hold = 1;
    do_reset();
    grant_log.delete();
    run(5);
    chk("s3_owed", pend.size(), 32'd2);
    cycle(1'b1, 32'h0000_1002);
    chk("s3_drain", dut.state_q, DRAIN);
    rv_hold = 0; grant_log.delete(); pop_log.delete();
    run(10);
    chk("s3_addr", grant_log[0], 32'h0000_1000);
    chk("s3_pc", pop_log[0], 32'h0000_1000);

    // grant withheld for five cycles
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 10 && grant_log.size() < 1; i++) cycle(1'b0, 32'd0);
    chk("s4_first", grant_log.size(), 32'd1);
    gnt_pct = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'd0);
      chk("s4_req_hold", imem_req, 32'd1);
      chk("s4_addr_hold", imem_addr, 32'h4);
    end
    gnt_pct = 100;
    cycle(1'b0, 32'd0);
    chk("s4_ngnt", grant_log.size(), 32'd2);
    chk("s4_gaddr", grant_log[1], 32'h4);
    chk("s4_next", imem_addr, 32'h8);

    // reset while draining
    rv_hold = 1;
    do_reset();
    run(5);
    cycle(1'b1, 32'h0000_2000);
    chk("s5_drain", dut.state_q, DRAIN);
    rv_hold = 0;
    do_reset();
    grant_log.delete();
    run(5);
    chk("s5_boot", grant_log[0], BOOT);

    // redirect colliding with a pop and a response
    rdy_pct = 0;
    do_reset();
    run(3);
    chk("s6_buf", sb_q.size(), 32'd1);
    chk("s6_owed", pend.size(), 32'd1);
    rdy_pct = 100; pop_log.delete();
    cycle(1'b1, 32'h0000_3000);
    chk("s6_vld", instr_valid, 32'd0);
    run(8);
    chk("s6_pc", pop_log[0], 32'h0000_3000);

    // randomized traffic
    nop_mode = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gnt_pct = $urandom_range(100, 20);
        rv_pct  = $urandom_range(100, 30);
        rv_max  = $urandom_range(3);
        rdy_pct = $urandom_range(100, 20);
      end
      if ($urandom_range(999) < 3) do_reset();
      else cycle($urandom_range(99) < 5, $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kamus_if.md
KAMUS_IF -- requirements
Module: kamus_if

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req_o  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr_o  output  32  fetch word address; bits [1:0] always 0.
REQ-007 SHALL have port imem_gnt_i  input  1  request accepted in this cycle.
REQ-008 SHALL have port imem_rvalid_i  input  1  response data valid.
REQ-009 SHALL have port imem_rdata_i  input  32  instruction word.
REQ-010 SHALL have port redirect_i  input  1  control-flow change (branch, jump, trap).
REQ-011 SHALL have port redirect_pc_i  input  32  new fetch target.
REQ-012 SHALL have port instr_valid_o  output  1  instr_o/pc_o valid toward the decoder.
REQ-013 SHALL have port instr_ready_i  input  1  decoder accepts the instruction.
REQ-014 SHALL have port instr_o  output  32  raw instruction word for kamus_ID.
REQ-015 SHALL have port pc_o  output  32  address of instr_o.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH and DRAIN; IDLE lasts exactly one cycle after reset release, then goes to FETCH.
REQ-017 Memory handshake: a request transfers when imem_req_o and imem_gnt_i are both high; while the request is ungranted, req and addr SHALL hold stable, except in a redirect cycle.
REQ-018 fetch_pc SHALL advance by 4 on each granted request, wrapping modulo 2^32.
REQ-019 In FETCH, imem_req_o SHALL be high only while (outstanding + buffered) < FIFO_DEPTH, which guarantees that every response has a free slot.
REQ-020 Responses arrive in order, exactly one per grant, at least 1 cycle after the grant; each response SHALL be pushed as {resp_pc, rdata}, and resp_pc SHALL then advance by 4.
REQ-021 Buffer output is registered: a response in cycle N SHALL make instr_valid_o high in cycle N+1 if the FIFO was empty.
REQ-022 instr_valid_o SHALL equal FIFO non-empty; the head SHALL pop on instr_valid_o and instr_ready_i both high; push and pop in the same cycle are allowed when full.
REQ-023 instr_o and pc_o SHALL both be 0 while instr_valid_o is low.
REQ-024 On redirect_i:
- FIFO flushed; instr_valid_o low next cycle.
- fetch_pc and resp_pc loaded with {redirect_pc_i[31:2],2'b00}.
- imem_req_o forced low in that cycle.
REQ-025 Redirect with responses still owed: count = outstanding + grant this cycle - rvalid this cycle. If the count is >0, go to DRAIN with drop_cnt = count; otherwise go to FETCH.
REQ-026 DRAIN: imem_req_o low; every imem_rvalid_i discarded and drop_cnt decremented; on reaching 0, go to FETCH at the redirect target.
REQ-027 A redirect in DRAIN SHALL update the target and stay in DRAIN without changing drop_cnt; a redirect and a pop in the same cycle SHALL resolve with redirect winning.
REQ-028 imem_rvalid_i with zero outstanding SHALL be ignored and flagged by an assertion.

Reset
REQ-029 Asserting rst_ni SHALL immediately force these values:
- imem_req_o=0, imem_addr_o=BOOT_ADDR.
- instr_valid_o=0, instr_o=0, pc_o=0.
- FIFO empty, outstanding=0, drop_cnt=0, state IDLE.
REQ-030 Reset mid-operation SHALL abandon all in-flight and buffered instructions, and fetch SHALL restart at BOOT_ADDR.

Structure
REQ-031 kamus_pkg SHALL hold fetch_state_e {IDLE, FETCH, DRAIN} and fetch_entry_t {pc[31:0], instr[31:0]}.
REQ-032 The buffer SHALL be a sub-module kamus_fifo: generic synchronous FIFO with flush, full/empty and count outputs, using the same clock and reset.

Verification
REQ-033 Stimulus: reset release, gnt_i=1, rvalid 1 cycle after grant with rdata 0x00000013, ready=1 -> required: addresses 0x0, 0x4, 0x8; instr_valid_o rises 1 cycle after the first rvalid with pc_o=0x0.
REQ-034 Stimulus: ready=0 throughout -> required: imem_req_o drops once 2 (FIFO_DEPTH) requests are granted; no further grants; instr_o holds the pc 0x0 word.
REQ-035 Stimulus: 2 outstanding, redirect_pc_i=0x0000_1002 -> required: DRAIN; 2 responses discarded; next imem_addr_o=0x0000_1000; first delivered pc_o=0x0000_1000.
REQ-036 Stimulus: gnt_i low for 5 cycles -> required: imem_req_o=1 and imem_addr_o=0x4 stable throughout; then one grant and addr 0x8.
REQ-037 Stimulus: rst_ni asserted during DRAIN -> required: all outputs at reset values in the same cycle; after release, first address BOOT_ADDR.
REQ-038 Stimulus: redirect in the same cycle as a pop and a response -> required: response discarded; instr_valid_o=0 next cycle; no stale pc delivered.
